// File: rtl/word_divider.sv
// word_divider
//   Multi-cycle unsigned restoring divider: Quotient = A / B, Remainder = A % B.
//   Produces one quotient bit per clock. The trial subtraction is done with a
//   carry-lookahead adder tiled from 4-bit lookahead groups, fed with A + ~B + 1,
//   so a carry out of 1 means "no borrow" (the shifted remainder is >= divisor).
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   Start      in   1      request, sampled only when idle
//   A          in   WIDTH  dividend, captured with Start
//   B          in   WIDTH  divisor, captured with Start
//   Busy       out  1      high while iterating (RUN)
//   Done       out  1      one-cycle pulse, results valid
//   Quotient   out  WIDTH  registered quotient, held until the next Done
//   Remainder  out  WIDTH  registered remainder, held until the next Done
//   DivByZero  out  1      registered, set with Done when the captured B was 0
module word_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             zero_pend;
  logic             zero_pend_nxt;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;

  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] diff;
  logic             cout;
  logic [WIDTH-1:0] q_shift;
  logic [WIDTH-1:0] r_next;
  logic             accept;
  logic             last_iter;

  // Carry-lookahead adder built from 4-bit lookahead groups; the group carry
  // ripples from one group to the next, exactly as a chain of four_bit_CLA
  // blocks would. Returns {carry_out, sum}.
  function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             cin);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] s;
    logic [4:0]       gc;
    logic             c;
    p = a ^ b;
    g = a & b;
    s = '0;
    c = cin;
    for (int k = 0; k < WIDTH / 4; k++) begin
      gc[0] = c;
      gc[1] = g[4*k] | (p[4*k] & c);
      gc[2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c);
      gc[3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
            | (p[4*k+2] & p[4*k+1] & p[4*k] & c);
      gc[4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c);
      for (int j = 0; j < 4; j++) begin
        s[4*k+j] = p[4*k+j] ^ gc[j];
      end
      c = gc[4];
    end
    return {c, s};
  endfunction

  // Iteration datapath: shift the next dividend bit into the partial
  // remainder, then trial-subtract the divisor. The partial remainder after
  // i iterations is below 2^i, so the shift never loses a set bit.
  assign rs              = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
  assign {cout, diff}    = cla_add(rs, ~d_reg, 1'b1);
  assign q_shift         = {q_reg[WIDTH-2:0], cout};
  assign r_next          = cout ? diff : rs;

  // A pending divide-by-zero blocks new requests until it has reported.
  assign accept    = (state == IDLE) && !zero_pend && Start;
  assign last_iter = (state == RUN) && (cnt == CNT_W'(1));

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    zero_pend_nxt = zero_pend;
    case (state)
      IDLE: begin
        if (zero_pend) begin
          // Divide by zero skips RUN but still reports one cycle after capture.
          state_nxt     = DONE;
          zero_pend_nxt = 1'b0;
        end else if (Start) begin
          if (B != '0) begin
            state_nxt = RUN;
            cnt_nxt   = CNT_W'(WIDTH);
          end else begin
            zero_pend_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      zero_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      zero_pend <= zero_pend_nxt;
    end
  end

  // Working registers carry data only; their contents are meaningless until
  // a request is accepted, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_reg <= A;
      d_reg <= B;
      r_reg <= '0;
    end else if (state == RUN) begin
      q_reg <= q_shift;
      r_reg <= r_next;
    end
  end

  // Result registers load on entry to DONE and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else if (last_iter) begin
      Quotient  <= q_shift;
      Remainder <= r_next;
      DivByZero <= 1'b0;
    end else if ((state == IDLE) && zero_pend) begin
      // q_reg still holds the captured dividend here.
      Quotient  <= '1;
      Remainder <= q_reg;
      DivByZero <= 1'b1;
    end
  end

endmodule
